// File: rtl/e203_exu_longp_cmt_buf.sv
// Long-pipe result buffer: holds LSU responses and retires them in OITF order,
// steering clean results to regfile writeback and faulting ones to commit as exceptions.
module e203_exu_longp_cmt_buf #(
    parameter int DEPTH  = 2,
    parameter int ITAG_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              lsu_i_valid,
    output logic              lsu_i_ready,
    input  logic [ITAG_W-1:0] lsu_i_itag,
    input  logic [31:0]       lsu_i_wdat,
    input  logic [4:0]        lsu_i_rdidx,
    input  logic              lsu_i_rdwen,
    input  logic              lsu_i_ld,
    input  logic              lsu_i_st,
    input  logic              lsu_i_buserr,
    input  logic              lsu_i_insterr,
    input  logic [31:0]       lsu_i_badaddr,
    input  logic [31:0]       lsu_i_pc,

    input  logic              oitf_empty,
    input  logic [ITAG_W-1:0] oitf_ret_ptr,
    output logic              oitf_ret_ena,

    output logic              wbck_o_valid,
    input  logic              wbck_o_ready,
    output logic [31:0]       wbck_o_wdat,
    output logic [4:0]        wbck_o_rdidx,

    output logic              longp_excp_o_valid,
    input  logic              longp_excp_o_ready,
    output logic              longp_excp_o_ld,
    output logic              longp_excp_o_st,
    output logic              longp_excp_o_buserr,
    output logic              longp_excp_o_insterr,
    output logic [31:0]       longp_excp_o_badaddr,
    output logic [31:0]       longp_excp_o_pc,

    output logic [CNT_W-1:0]  excp_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [ITAG_W-1:0] itag;
        logic [31:0]       wdat;
        logic [4:0]        rdidx;
        logic              rdwen;
        logic              ld;
        logic              st;
        logic              buserr;
        logic              insterr;
        logic [31:0]       badaddr;
        logic [31:0]       pc;
    } entry_t;

    entry_t             buf_q [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    entry_t head;
    logic   head_vld;
    logic   eligible;
    logic   head_err;
    logic   excp_pop;
    logic   pop;
    logic   push;
    logic   full;

    // Outputs come only from registered head state, so there is no lsu_i -> output path.
    always_comb begin
        head      = buf_q[rd_ptr];
        head_vld  = vld_q[rd_ptr];
        eligible  = head_vld & !oitf_empty & (head.itag == oitf_ret_ptr);
        head_err  = head.buserr | head.insterr;

        longp_excp_o_valid = eligible & head_err;
        wbck_o_valid       = eligible & !head_err & head.rdwen;

        excp_pop = longp_excp_o_valid & longp_excp_o_ready;
        pop      = excp_pop
                 | (wbck_o_valid & wbck_o_ready)
                 | (eligible & !head_err & !head.rdwen);

        full        = vld_q[wr_ptr];
        lsu_i_ready = !full | pop;
        push        = lsu_i_valid & lsu_i_ready;

        oitf_ret_ena = pop;

        wbck_o_wdat  = wbck_o_valid ? head.wdat  : 32'd0;
        wbck_o_rdidx = wbck_o_valid ? head.rdidx : 5'd0;

        longp_excp_o_ld      = longp_excp_o_valid & head.ld;
        longp_excp_o_st      = longp_excp_o_valid & head.st;
        longp_excp_o_buserr  = longp_excp_o_valid & head.buserr;
        longp_excp_o_insterr = longp_excp_o_valid & head.insterr;
        longp_excp_o_badaddr = longp_excp_o_valid ? head.badaddr : 32'd0;
        longp_excp_o_pc      = longp_excp_o_valid ? head.pc      : 32'd0;
    end

    // Clear-then-set ordering lets a pop-through push reuse the slot being retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            excp_cnt <= '0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (excp_pop && (excp_cnt != {CNT_W{1'b1}})) begin
                excp_cnt <= excp_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_q[wr_ptr] <= '{itag:    lsu_i_itag,
                               wdat:    lsu_i_wdat,
                               rdidx:   lsu_i_rdidx,
                               rdwen:   lsu_i_rdwen,
                               ld:      lsu_i_ld,
                               st:      lsu_i_st,
                               buserr:  lsu_i_buserr,
                               insterr: lsu_i_insterr,
                               badaddr: lsu_i_badaddr,
                               pc:      lsu_i_pc};
        end
    end

endmodule
